mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single memory port between instruction fetch (IF) and the data path (loads/stores
//  flagged by is_load/is_store from decode). Sequences one transfer at a time via a 4-state FSM, holds
//  stable bus signals until mem_ready, returns read data with a one-cycle ack, and flags bus timeouts.
//  Sits between the IF/MEM pipeline stages and the external memory; its stall outputs feed hazard control.
// PARAMETERS
//  XLEN       32  data/address width (taken from `XLEN)
//  TIMEOUT    15  max BUSY cycles waiting for mem_ready before bus error (1..2^TMR_W-1)
//  TMR_W      4   width of wait counter
// PORTS
//  clk        in   1     core clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  if_req     in   1     fetch request; held with if_addr stable until if_ack
//  if_addr    in   XLEN  fetch address
//  if_rdata   out  XLEN  fetched instruction, valid with if_ack
//  if_ack     out  1     one-cycle completion pulse for fetch
//  d_req      in   1     data request (is_load | is_store); held with fields stable until d_ack
//  d_we       in   1     1 = store, 0 = load
//  d_addr     in   XLEN  data address
//  d_wdata    in   XLEN  store data
//  d_wstrb    in   4     store byte enables (ignored for loads)
//  d_rdata    out  XLEN  load data, valid with d_ack
//  d_ack      out  1     one-cycle completion pulse for data
//  if_stall   out  1     if_req & ~if_ack (combinational)
//  d_stall    out  1     d_req & ~d_ack (combinational)
//  mem_valid  out  1     bus request active
//  mem_we     out  1     bus write
//  mem_addr   out  XLEN  bus address
//  mem_wdata  out  XLEN  bus write data
//  mem_wstrb  out  4     bus byte enables (4'b0000 on reads)
//  mem_ready  in   1     memory completes transfer this cycle
//  mem_rdata  in   XLEN  read data, valid when mem_ready
//  bus_err    out  1     accompanies ack when transfer timed out
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, counter=0; every output 0; mem_valid drops immediately,
//    even mid-transfer; no ack is issued for the aborted transfer.
//  - All mem_*, *_ack, *_rdata, bus_err are registered. Stall outputs are combinational.
//  - IDLE: sample requests. d_req wins over if_req (older instruction; avoids pipeline deadlock).
//    d_req -> D_BUSY; else if_req -> IF_BUSY; mem_valid and bus fields load on same edge.
//  - IF_BUSY/D_BUSY: mem_valid=1, addr/we/wdata/wstrb held constant; counter increments per cycle
//    without mem_ready. mem_ready=1 -> capture mem_rdata into winner's rdata (0 for stores),
//    mem_valid=0, go RESP. counter reaches TIMEOUT with no ready -> mem_valid=0, rdata=0,
//    bus_err=1, go RESP.
//  - RESP: exactly one of if_ack/d_ack = 1 for this cycle (bus_err as set); requests not sampled;
//    next state IDLE, counter cleared, ack/bus_err clear. Requester may drop or change req next cycle.
//  - Latency: zero-wait memory -> ack 3 cycles after req seen in IDLE (IDLE,BUSY,RESP); back-to-back
//    throughput one transfer per 3 cycles. Each added wait state adds one cycle.
//  - Simultaneous if_req & d_req: data first; fetch served in the next IDLE if still asserted.
//  - mem_ready outside BUSY is ignored. req dropped mid-BUSY is a protocol violation; transfer
//    still completes and acks.
//  - rdata registers hold last value until next completion (cleared only by reset/timeout).
// STRUCTURE
//  - State encodings `ARB_IDLE/`ARB_IF_BUSY/`ARB_D_BUSY/`ARB_RESP (2-bit) and `XLEN live in
//    rtl/isa.v alongside existing opcode/ALU defines.
//  - One sub-module: mem_wait_timer (TMR_W counter with clear/enable, expired = count==TIMEOUT).
// TESTING
//  1. Reset then if_req, addr=0x100, mem_ready same cycle as mem_valid, rdata=0x00500093 ->
//     mem_valid 1 cycle, if_ack 1 cycle later with if_rdata=0x00500093, bus_err=0.
//  2. if_req and d_req(load,0x2000) in same cycle -> D_BUSY first, d_ack first; fetch granted in
//     following IDLE; mem_addr 0x2000 then 0x100.
//  3. Store d_addr=0x40, wdata=0xDEADBEEF, wstrb=4'b0011, mem_ready after 3 waits -> mem_we=1,
//    fields stable 4 cycles, d_ack with d_rdata=0, wstrb seen 0011.
//  4. mem_ready never asserted, TIMEOUT=15 -> mem_valid drops after 15 BUSY cycles, ack + bus_err=1,
//    rdata=0, FSM back to IDLE.
//  5. rst_n low during D_BUSY wait -> mem_valid/outputs 0 asynchronously, no d_ack; after release
//    new if_req served normally.
//  6. if_stall/d_stall equal req & ~ack every cycle across scenarios 1-4 (assertion check).

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared width and FSM state type for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_BUSY = 2'd1,
        ARB_D_BUSY  = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-bus signals of the arbiter
//   slave  : arbiter view (requests/mem_ready/mem_rdata in; acks, rdata, stalls, bus fields out)
//   master : environment view (core pipeline stages plus external memory)
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_ack;
    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_wstrb;
    logic [XLEN-1:0] d_rdata;
    logic            d_ack;
    logic            if_stall;
    logic            d_stall;
    logic            mem_valid;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;
    logic            bus_err;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack, if_stall, d_stall,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack, if_stall, d_stall,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// mem_wait_timer: wait-state counter with clear/enable; expired_o when count equals TIMEOUT
//   clk, rst_n : clock, async active-low reset
//   clr_i      : zero the count (dominates en_i)
//   en_i       : add one this cycle
//   expired_o  : count == TIMEOUT
module mem_wait_timer #(
    parameter int TMR_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [TMR_W-1:0] count_q, count_d;
    always_comb count_d = clr_i ? '0 : en_i ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
    assign expired_o = count_q == TMR_W'(TIMEOUT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, one transfer at a time
//   clk, rst_n : clock, async active-low reset
//   arb_if     : fetch/data request-ack channels, stalls, memory bus and bus_err (slave modport)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   arb_if
);
    arb_state_e      state_q, state_d;
    logic            mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic            if_ack_q, if_ack_d, d_ack_q, d_ack_d, bus_err_q, bus_err_d;
    logic            busy, grant, expired, tmo, done;
    assign busy  = state_q == ARB_IF_BUSY || state_q == ARB_D_BUSY;
    assign grant = state_q == ARB_IDLE && (arb_if.d_req || arb_if.if_req);
    // mem_ready in the expiry cycle still completes the transfer normally
    assign tmo   = busy && !arb_if.mem_ready && expired;
    assign done  = busy && (arb_if.mem_ready || expired);
    // the grant edge is counted too, so the count equals the number of BUSY cycles entered
    mem_wait_timer #(.TMR_W(TMR_W), .TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == ARB_RESP),
        .en_i      (grant || (busy && !arb_if.mem_ready)),
        .expired_o (expired)
    );
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            ARB_IDLE: if (grant) begin
                // data wins: it belongs to the older instruction
                state_d     = arb_if.d_req ? ARB_D_BUSY : ARB_IF_BUSY;
                mem_valid_d = 1'b1;
                mem_we_d    = arb_if.d_req && arb_if.d_we;
                mem_addr_d  = arb_if.d_req ? arb_if.d_addr : arb_if.if_addr;
                mem_wdata_d = arb_if.d_req ? arb_if.d_wdata : '0;
                mem_wstrb_d = (arb_if.d_req && arb_if.d_we) ? arb_if.d_wstrb : 4'b0000;
            end
            ARB_IF_BUSY, ARB_D_BUSY: if (done) begin
                state_d     = ARB_RESP;
                mem_valid_d = 1'b0;
                bus_err_d   = tmo;
                if_ack_d    = state_q == ARB_IF_BUSY;
                d_ack_d     = state_q == ARB_D_BUSY;
                if (state_q == ARB_IF_BUSY) if_rdata_d = tmo ? '0 : arb_if.mem_rdata;
                else                        d_rdata_d  = (tmo || mem_we_q) ? '0 : arb_if.mem_rdata;
            end
            default: state_d = ARB_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            bus_err_q   <= bus_err_d;
        end
    end
    assign arb_if.mem_valid = mem_valid_q;
    assign arb_if.mem_we    = mem_we_q;
    assign arb_if.mem_addr  = mem_addr_q;
    assign arb_if.mem_wdata = mem_wdata_q;
    assign arb_if.mem_wstrb = mem_wstrb_q;
    assign arb_if.if_rdata  = if_rdata_q;
    assign arb_if.d_rdata   = d_rdata_q;
    assign arb_if.if_ack    = if_ack_q;
    assign arb_if.d_ack     = d_ack_q;
    assign arb_if.bus_err   = bus_err_q;
    assign arb_if.if_stall  = arb_if.if_req && !if_ack_q;
    assign arb_if.d_stall   = arb_if.d_req && !d_ack_q;
endmodule
